rv32_decode_queue: RTL and testbench
====================================

RV32_DECODE_QUEUE -- requirements
Module: rv32_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter XLEN, default 32: width of pc and instr fields.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset, sampled on posedge clk.
REQ-005 SHALL have port flush_in, input, 1: discard all queued entries and any push in the same cycle.
REQ-006 SHALL have port in_valid, input, 1: fetch presents an entry.
REQ-007 SHALL have port in_ready, output, 1: queue accepts an entry this cycle.
REQ-008 SHALL have port pc_in, input, XLEN: pc of the pushed entry.
REQ-009 SHALL have port instr_in, input, XLEN: instruction word of the pushed entry.
REQ-010 SHALL have port branch_predicted_taken_in, input, 1: fetch prediction bit of the pushed entry.
REQ-011 SHALL have port out_valid, output, 1: head entry is valid.
REQ-012 SHALL have port out_ready, input, 1: decode consumes the head this cycle (the inverse of decode stall).
REQ-013 SHALL have port pc_out, output, XLEN: head pc.
REQ-014 SHALL have port instr_out, output, XLEN: head instruction.
REQ-015 SHALL have port branch_predicted_taken_out, output, 1: head prediction bit.
REQ-016 SHALL have port count_out, output, $clog2(DEPTH+1): number of valid entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready && !flush_in; pop SHALL occur when out_valid && out_ready && !flush_in.
REQ-018 in_ready SHALL equal (count != DEPTH), driven from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); pc_out, instr_out and branch_predicted_taken_out SHALL be read from the entry at the read pointer.
REQ-020 Latency: a pushed entry SHALL appear at the head no earlier than the cycle after the push; there is no same-cycle bypass.
REQ-021 Ordering SHALL be strictly FIFO; each accepted entry SHALL be output exactly once unless it is flushed.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-023 count update: push only +1; pop only -1; push and pop in the same cycle leave count unchanged.
REQ-024 Full (count==DEPTH): in_ready=0, so a pop in that cycle frees a slot that is usable only from the next cycle.
REQ-025 Empty (count==0): out_valid=0; out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-026 Flush: next-cycle count=0, out_valid=0, in_ready=1, and both pointers reset to 0.
REQ-027 Flush SHALL take priority over any push or pop in the same cycle.
REQ-028 Head data outputs are don't-care while out_valid=0, but SHALL NOT be X after reset.
REQ-029 Storage SHALL have no effect on pc, instr or prediction bits other than holding them; bits written SHALL be the bits read.

Reset
REQ-030 While reset_n=0 at posedge clk: read/write pointers=0, count_out=0, out_valid=0, in_ready=1.
REQ-031 While reset_n=0 at posedge clk, all storage entries SHALL be cleared to 0, so head data outputs read 0.
REQ-032 Reset SHALL override flush_in, push and pop.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries within one cycle.
REQ-034 The first push after reset_n rises SHALL be accepted in the cycle reset_n is first sampled high.

Verification
REQ-035 Reset then push pc=0x100/instr=0x00000013 with out_ready=0 -> next cycle out_valid=1, pc_out=0x100, count_out=1.
REQ-036 DEPTH=2, push 0x100, 0x104, 0x108 on consecutive cycles with out_ready=0 -> in_ready=0 after the second push, third entry not accepted, count_out=2.
REQ-037 Full queue, out_ready=1 and in_valid=1 for 8 cycles with pc incrementing by 4 -> outputs in push order, no duplicates, pointers wrap at least 3 times.
REQ-038 count=1, push and pop in the same cycle -> count_out stays 1, head advances to the new entry.
REQ-039 count=2, flush_in=1 with in_valid=1 and out_ready=1 -> next cycle count_out=0, out_valid=0, pushed entry never appears.
REQ-040 count=2, reset_n=0 for one cycle -> count_out=0, pc_out=0, in_ready=1; a push on the following cycle is output correctly.

Source files
------------

// File: rtl/rv32_decode_queue.sv
// rv32_decode_queue: fetch-to-decode FIFO holding pc, instruction and branch prediction
module rv32_decode_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [XLEN-1:0]            instr_in,
    input  logic                       branch_predicted_taken_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            instr_out,
    output logic                       branch_predicted_taken_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic            bpt_q   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid && in_ready && !flush_in;
    assign pop        = out_valid && out_ready && !flush_in;
    assign count_out  = count;
    assign pc_out     = pc_q[rd_ptr];
    assign instr_out  = instr_q[rd_ptr];
    assign branch_predicted_taken_out = bpt_q[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (!reset_n || flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
        end
    end

    // Entry storage, cleared on reset so the head never reads X
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                bpt_q[i]   <= 1'b0;
            end
        end else if (push) begin
            pc_q[wr_ptr]    <= pc_in;
            instr_q[wr_ptr] <= instr_in;
            bpt_q[wr_ptr]   <= branch_predicted_taken_in;
        end
    end
endmodule

// File: tb/tb_rv32_decode_queue.sv
// tb_rv32_decode_queue: directed self-checking bench for rv32_decode_queue
module tb_rv32_decode_queue;
    logic        clk = 1'b0;
    logic        reset_n, flush_in, in_valid, in_ready, bpt_in;
    logic        out_valid, out_ready, bpt_out;
    logic [31:0] pc_in, instr_in, pc_out, instr_out;
    logic [1:0]  count_out;
    int          errors = 0;
    int          checks = 0;

    rv32_decode_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in), .branch_predicted_taken_in(bpt_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out), .branch_predicted_taken_out(bpt_out),
        .count_out(count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc[$];
    logic [31:0] exp_ins[$];
    logic [31:0] next_pc;
    logic        acc, popd;

    initial begin
        reset_n = 0; flush_in = 0; in_valid = 1; out_ready = 0;
        pc_in = 32'h0; instr_in = 32'h0; bpt_in = 0;
        step(); in_valid = 0; step();
        chk("rst_count", 32'(count_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_instr_out", instr_out, 0);

        reset_n = 1; in_valid = 1; pc_in = 32'h100; instr_in = 32'h00000013; bpt_in = 1;
        chk("no_bypass_valid", 32'(out_valid), 0);
        step();
        chk("push1_valid", 32'(out_valid), 1);
        chk("push1_pc", pc_out, 32'h100);
        chk("push1_instr", instr_out, 32'h13);
        chk("push1_bpt", 32'(bpt_out), 1);
        chk("push1_count", 32'(count_out), 1);

        pc_in = 32'h104; instr_in = 32'h1104; bpt_in = 0;
        step();
        chk("full_count", 32'(count_out), 2);
        chk("full_in_ready", 32'(in_ready), 0);
        pc_in = 32'h108; instr_in = 32'h1108;
        step();
        chk("full_reject_count", 32'(count_out), 2);
        chk("full_head_pc", pc_out, 32'h100);

        exp_pc = {32'h100, 32'h104};
        exp_ins = {32'h13, 32'h1104};
        next_pc = 32'h108;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            pc_in = next_pc; instr_in = next_pc + 32'h1000;
            chk("stream_count", 32'(count_out), 32'(exp_pc.size()));
            chk("stream_in_ready", 32'(in_ready), 32'(exp_pc.size() != 2));
            chk("stream_pc", pc_out, exp_pc[0]);
            chk("stream_instr", instr_out, exp_ins[0]);
            acc = exp_pc.size() != 2;
            popd = exp_pc.size() != 0;
            step();
            if (popd) begin
                void'(exp_pc.pop_front());
                void'(exp_ins.pop_front());
            end
            if (acc) begin
                exp_pc.push_back(next_pc);
                exp_ins.push_back(next_pc + 32'h1000);
                next_pc = next_pc + 4;
            end
        end
        chk("stream_end_count", 32'(count_out), 1);
        chk("stream_end_pc", pc_out, exp_pc[0]);

        pc_in = 32'h200; instr_in = 32'h2200; bpt_in = 1;
        step();
        chk("pushpop_count", 32'(count_out), 1);
        chk("pushpop_pc", pc_out, 32'h200);
        chk("pushpop_bpt", 32'(bpt_out), 1);

        out_ready = 0; pc_in = 32'h204; instr_in = 32'h2204; bpt_in = 0;
        step();
        chk("fill2_count", 32'(count_out), 2);

        flush_in = 1; out_ready = 1; pc_in = 32'h300; instr_in = 32'h3300;
        step();
        chk("flush_count", 32'(count_out), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        flush_in = 0; in_valid = 0;
        step();
        chk("flush_no_ghost", 32'(out_valid), 0);
        chk("empty_pop_no_underflow", 32'(count_out), 0);

        in_valid = 1; out_ready = 0; pc_in = 32'h310; instr_in = 32'h3310;
        step();
        chk("post_flush_pc", pc_out, 32'h310);
        pc_in = 32'h314; instr_in = 32'h3314;
        step();
        chk("post_flush_count", 32'(count_out), 2);

        reset_n = 0; in_valid = 1; out_ready = 1; pc_in = 32'h400;
        step();
        chk("midrst_count", 32'(count_out), 0);
        chk("midrst_pc", pc_out, 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);

        reset_n = 1; out_ready = 0; pc_in = 32'h500; instr_in = 32'h33;
        step();
        chk("after_rst_pc", pc_out, 32'h500);
        chk("after_rst_instr", instr_out, 32'h33);
        chk("after_rst_count", 32'(count_out), 1);
        in_valid = 0; out_ready = 1;
        step();
        chk("drain_count", 32'(count_out), 0);
        chk("drain_out_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
